// File: rtl/d_lock_ctrl.sv
// Digital-lock sequencing controller: keypad entry, code check, lockout.
// Optional LOCK_PERSIST_ERR_EN keeps the error count at MAX_ERR-1 after lockout.
module d_lock_ctrl #(
    parameter int CODE_LEN = 4,
    parameter int DIGIT_W  = 4,
    parameter int MAX_ERR  = 3,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_enter,
    input  logic               key_clear,
    input  logic               set_req,
    input  logic               tmr_enb_set,
    input  logic               tmr_enb_inp,
    input  logic               tmr_reset,
    output logic               enb_lock,
    output logic               disable_cnt,
    output logic               enb_cnt,
    output logic               ignore,
    output logic               gen_stop,
    output logic [2:0]         error_counter,
    output logic               unlocked
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_SET_CODE, S_LOCKOUT
    } state_t;

    state_t             state, state_n;
    logic [CODE_W-1:0]  code, code_n;
    logic [CODE_W-1:0]  buffer, buf_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               forced, forced_n;
    logic [2:0]         err_n, err_inc;
    logic               full, push;
    logic               ign_n, lock_n, dis_n, run_n, stop_n, unl_n;

    assign full    = (cnt == CNT_W'(CODE_LEN));
    assign err_inc = (error_counter == 3'd7) ? 3'd7 : error_counter + 3'd1;

    always_comb begin
        state_n  = state;
        code_n   = code;
        buf_n    = buffer;
        cnt_n    = cnt;
        forced_n = forced;
        err_n    = error_counter;
        ign_n    = 1'b0;
        push     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (key_valid) begin
                    if (tmr_enb_inp) begin
                        buf_n   = CODE_W'(key_digit);
                        cnt_n   = CNT_W'(1);
                        state_n = S_ENTRY;
                    end else begin
                        ign_n = 1'b1;
                    end
                end
            end
            S_ENTRY: begin
                // An entry timeout counts as a failed attempt.
                if (tmr_reset) begin
                    forced_n = 1'b1;
                    state_n  = S_CHECK;
                end else if (key_clear) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (key_enter) begin
                    forced_n = 1'b0;
                    state_n  = S_CHECK;
                end else if (key_valid) begin
                    push = 1'b1;
                end
            end
            S_CHECK: begin
                buf_n    = '0;
                cnt_n    = '0;
                forced_n = 1'b0;
                if (!forced && full && buffer == code) begin
                    err_n   = '0;
                    state_n = S_UNLOCKED;
                end else begin
                    err_n   = err_inc;
                    state_n = (int'(err_inc) >= MAX_ERR) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (tmr_reset || key_enter) begin
                    state_n = S_IDLE;
                end else if (set_req && tmr_enb_set) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = S_SET_CODE;
                end else if (key_valid) begin
                    ign_n = 1'b1;
                end
            end
            S_SET_CODE: begin
                if (key_clear) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    state_n = S_UNLOCKED;
                end else if (key_enter) begin
                    if (full) begin
                        code_n  = buffer;
                        buf_n   = '0;
                        cnt_n   = '0;
                        state_n = S_UNLOCKED;
                    end else begin
                        ign_n = 1'b1;
                    end
                end else if (key_valid) begin
                    push = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (tmr_reset) begin
                    state_n = S_IDLE;
`ifdef LOCK_PERSIST_ERR_EN
                    err_n   = 3'(MAX_ERR - 1);
`else
                    err_n   = '0;
`endif
                end else if (key_valid || key_enter || key_clear) begin
                    ign_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (push) begin
            if (full) begin
                ign_n = 1'b1;
            end else begin
                buf_n = (buffer << DIGIT_W) | CODE_W'(key_digit);
                cnt_n = cnt + CNT_W'(1);
            end
        end

        // Outputs are decoded from the next state so they register with it.
        lock_n = 1'b1;
        dis_n  = 1'b0;
        run_n  = 1'b0;
        stop_n = 1'b0;
        unl_n  = 1'b0;
        unique case (state_n)
            S_ENTRY: run_n = 1'b1;
            S_UNLOCKED: begin
                lock_n = 1'b0;
                unl_n  = 1'b1;
                run_n  = 1'b1;
            end
            S_SET_CODE: begin
                lock_n = 1'b0;
                unl_n  = 1'b1;
                dis_n  = 1'b1;
            end
            S_LOCKOUT: begin
                stop_n = 1'b1;
                run_n  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            code          <= DEFAULT_CODE;
            buffer        <= '0;
            cnt           <= '0;
            forced        <= 1'b0;
            error_counter <= '0;
            enb_lock      <= 1'b1;
            disable_cnt   <= 1'b0;
            enb_cnt       <= 1'b0;
            ignore        <= 1'b0;
            gen_stop      <= 1'b0;
            unlocked      <= 1'b0;
        end else begin
            state         <= state_n;
            code          <= code_n;
            buffer        <= buf_n;
            cnt           <= cnt_n;
            forced        <= forced_n;
            error_counter <= err_n;
            enb_lock      <= lock_n;
            disable_cnt   <= dis_n;
            enb_cnt       <= run_n;
            ignore        <= ign_n;
            gen_stop      <= stop_n;
            unlocked      <= unl_n;
        end
    end

endmodule

// File: tb/tb_d_lock_ctrl.sv
// Self-checking bench for d_lock_ctrl: directed plan plus random traffic
// against a digit-queue reference model.
module tb_d_lock_ctrl;

    localparam int MAX_ERR = 3;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       key_valid, key_enter, key_clear;
    logic [3:0] key_digit;
    logic       set_req, tmr_enb_set, tmr_enb_inp, tmr_reset;
    logic       enb_lock, disable_cnt, enb_cnt, ignore, gen_stop, unlocked;
    logic [2:0] error_counter;

    int tests = 0;
    int fails = 0;

    d_lock_ctrl dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .key_valid(key_valid), .key_digit(key_digit),
        .key_enter(key_enter), .key_clear(key_clear),
        .set_req(set_req), .tmr_enb_set(tmr_enb_set),
        .tmr_enb_inp(tmr_enb_inp), .tmr_reset(tmr_reset),
        .enb_lock(enb_lock), .disable_cnt(disable_cnt),
        .enb_cnt(enb_cnt), .ignore(ignore), .gen_stop(gen_stop),
        .error_counter(error_counter), .unlocked(unlocked)
    );

    always #4 clk_in = ~clk_in;

    // Reference model: modes, a digit queue and a four-digit code.
    localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2;
    localparam int M_OPEN = 3, M_SET = 4, M_LOCK = 5;
    int m_mode;
    int m_err;
    int m_dig[$];
    int m_code[4];
    bit m_forced;
    bit m_ign;

    function automatic bit code_match();
        if (m_dig.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (m_dig[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_digit(int d);
        if (m_dig.size() == 4) m_ign = 1'b1;
        else m_dig.push_back(d);
    endtask

    task automatic model_step();
        m_ign = 1'b0;
        if (!reset_n) begin
            m_mode = M_IDLE;
            m_err = 0;
            m_dig.delete();
            m_code = '{1, 2, 3, 4};
            m_forced = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE:
                if (key_valid) begin
                    if (tmr_enb_inp) begin
                        m_dig.delete();
                        m_dig.push_back(int'(key_digit));
                        m_mode = M_ENTRY;
                    end else m_ign = 1'b1;
                end
            M_ENTRY:
                if (tmr_reset) begin
                    m_forced = 1'b1; m_mode = M_CHECK;
                end else if (key_clear) begin
                    m_dig.delete(); m_mode = M_IDLE;
                end else if (key_enter) begin
                    m_forced = 1'b0; m_mode = M_CHECK;
                end else if (key_valid) push_digit(int'(key_digit));
            M_CHECK: begin
                if (!m_forced && code_match()) begin
                    m_err = 0; m_mode = M_OPEN;
                end else begin
                    m_err = (m_err >= 7) ? 7 : m_err + 1;
                    m_mode = (m_err >= MAX_ERR) ? M_LOCK : M_IDLE;
                end
                m_dig.delete();
                m_forced = 1'b0;
            end
            M_OPEN:
                if (tmr_reset || key_enter) m_mode = M_IDLE;
                else if (set_req && tmr_enb_set) begin
                    m_dig.delete(); m_mode = M_SET;
                end else if (key_valid) m_ign = 1'b1;
            M_SET:
                if (key_clear) begin
                    m_dig.delete(); m_mode = M_OPEN;
                end else if (key_enter) begin
                    if (m_dig.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_code[i] = m_dig[i];
                        m_dig.delete(); m_mode = M_OPEN;
                    end else m_ign = 1'b1;
                end else if (key_valid) push_digit(int'(key_digit));
            M_LOCK:
                if (tmr_reset) begin
                    m_mode = M_IDLE;
`ifdef LOCK_PERSIST_ERR_EN
                    m_err = MAX_ERR - 1;
`else
                    m_err = 0;
`endif
                end else if (key_valid || key_enter || key_clear) m_ign = 1'b1;
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [8:0] expected();
        bit open = (m_mode == M_OPEN) || (m_mode == M_SET);
        bit run = (m_mode == M_ENTRY) || (m_mode == M_OPEN) || (m_mode == M_LOCK);
        return {~open, m_mode == M_SET, run, m_ign, m_mode == M_LOCK, open, 3'(m_err)};
    endfunction

    task automatic tick(string tag);
        logic [8:0] got, exp;
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        got = {enb_lock, disable_cnt, enb_cnt, ignore, gen_stop, unlocked, error_counter};
        exp = expected();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
        reset_n = 1'b1;
        key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; tmr_reset = 1'b0;
    endtask

    task automatic check_bit(string tag, logic got, logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic key(int d);
        key_valid = 1'b1; key_digit = 4'(d); tick("key");
    endtask

    task automatic enter();
        key_enter = 1'b1; tick("enter");
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tick("reset");
    endtask

    task automatic type4(int a, int b, int c, int d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        reset_n = 1'b0;
        key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_digit = '0;
        set_req = 1'b0; tmr_enb_set = 1'b0; tmr_enb_inp = 1'b1; tmr_reset = 1'b0;
        @(negedge clk_in);
        do_reset();
        check_bit("reset_lock", enb_lock, 1'b1);
        check_bit("reset_err0", error_counter == 3'd0, 1'b1);

        // Correct code: one CHECK cycle, then unlocked.
        type4(1, 2, 3, 4);
        enter();
        check_bit("check_still_locked", enb_lock, 1'b1);
        tick("check");
        check_bit("open_unlocked", unlocked, 1'b1);
        check_bit("open_lock_off", enb_lock, 1'b0);
        enter();

        // Three wrong entries lead to lockout.
        for (int k = 0; k < 3; k++) begin
            type4(1, 2, 3, 5);
            enter();
            tick("wrong_check");
            check_bit("err_step", error_counter == 3'(k + 1), 1'b1);
        end
        check_bit("lockout_stop", gen_stop, 1'b1);
        key(7);
        check_bit("lockout_ignore", ignore, 1'b1);
        tick("ignore_drop");
        check_bit("ignore_one_cycle", ignore, 1'b0);
        key_clear = 1'b1; tick("lock_clear");
        tmr_reset = 1'b1; tick("lock_exit");

        // Short entry, then overflow digit dropped.
        do_reset();
        key(1); key(2); key(3); enter(); tick("short_check");
        check_bit("short_err1", error_counter == 3'd1, 1'b1);
        type4(1, 2, 3, 4);
        key(9);
        check_bit("overflow_ignore", ignore, 1'b1);
        enter(); tick("ovf_check");
        check_bit("ovf_unlock", unlocked, 1'b1);

        // Code change to 9876.
        set_req = 1'b1; tmr_enb_set = 1'b1; tick("set_enter");
        set_req = 1'b0;
        check_bit("set_disable", disable_cnt, 1'b1);
        key(9); enter();
        check_bit("set_short_ignore", ignore, 1'b1);
        key(8); key(7); key(6); enter();
        tmr_reset = 1'b1; tick("relock");
        type4(9, 8, 7, 6); enter(); tick("new_check");
        check_bit("new_code_open", unlocked, 1'b1);
        enter();
        type4(1, 2, 3, 4); enter(); tick("old_check");
        check_bit("old_code_fails", unlocked, 1'b0);

        // Priority: timeout beats enter; clear beats enter.
        key(9); key(8);
        tmr_reset = 1'b1; key_enter = 1'b1; tick("tmo_enter");
        tick("tmo_check");
        key(9);
        key_clear = 1'b1; key_enter = 1'b1; tick("clear_enter");
        tick("after_clear");

        // Reset during lockout restores default code.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            key(5); enter(); tick("lk_check");
        end
        reset_n = 1'b0; tick("reset_in_lock");
        check_bit("rst_lock_stop", gen_stop, 1'b0);
        type4(1, 2, 3, 4); enter(); tick("dflt_check");
        check_bit("default_code_back", unlocked, 1'b1);

        // Randomized traffic.
        for (int it = 0; it < 500; it++) begin
            int r;
            tmr_enb_inp = ($urandom_range(0, 7) != 0);
            tmr_enb_set = $urandom_range(0, 1);
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2: begin
                    int c[4];
                    c = m_code;
                    for (int i = 0; i < 4; i++) key(c[i]);
                    enter();
                end
                3, 4: key($urandom_range(0, 15));
                5: enter();
                6: begin key_clear = 1'b1; tick("rnd_clear"); end
                7: begin tmr_reset = 1'b1; tick("rnd_tmr"); end
                8: begin set_req = 1'b1; tick("rnd_set"); set_req = 1'b0; end
                9: begin
                    key_valid = $urandom_range(0, 1);
                    key_digit = 4'($urandom_range(0, 15));
                    key_enter = $urandom_range(0, 1);
                    key_clear = $urandom_range(0, 1);
                    tmr_reset = $urandom_range(0, 1);
                    tick("rnd_multi");
                end
                10: tick("rnd_idle");
                default: if ($urandom_range(0, 9) == 0) do_reset(); else tick("rnd_idle2");
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/d_lock_ctrl.md
Name: d_lock_ctrl

Overview:
- Sequencing controller for the digital-lock timer/LED subsystem.
- Collects keypad digits, compares the entry with the stored code and counts failed attempts.
- Drives the timer control inputs: enb_lock, disable_cnt, enb_cnt, ignore, gen_stop and error_counter.
- Consumes the timer handshake outputs (enb_set, enb_inp, reset) to sequence unlock, relock, code change and lockout.

Parameters:
- CODE_LEN, 4: digits per code, 1..8.
- DIGIT_W, 4: bits per digit.
- MAX_ERR, 3: failed attempts that trigger lockout, 1..7.
- DEFAULT_CODE, 16'h1234: code loaded at reset, width CODE_LEN*DIGIT_W.

Ports:
- clk_in, in, 1: system clock, 125 MHz.
- reset_n, in, 1: synchronous reset, active-low.
- key_valid, in, 1: one-cycle pulse; key_digit is valid.
- key_digit, in, DIGIT_W: digit value.
- key_enter, in, 1: one-cycle pulse; submit entry.
- key_clear, in, 1: one-cycle pulse; discard entry.
- set_req, in, 1: level; request a code change.
- tmr_enb_set, in, 1: timer grants code-set window.
- tmr_enb_inp, in, 1: timer permits digit input.
- tmr_reset, in, 1: timer expiry pulse (timeout, relock or lockout end).
- enb_lock, out, 1: lock engaged.
- disable_cnt, out, 1: freeze timer count.
- enb_cnt, out, 1: run timer count.
- ignore, out, 1: one-cycle pulse; a key was dropped.
- gen_stop, out, 1: lockout indication to timer.
- error_counter, out, 3: failed-attempt count.
- unlocked, out, 1: status.

Behaviour:
- Clocking and reset:
  - All state and outputs are registered. Outputs change 1 cycle after the causing input edge.
  - reset_n low at a clk_in edge: state=IDLE, code=DEFAULT_CODE, entry buffer=0, digit count=0, error_counter=0, enb_lock=1, all other outputs 0.
  - Reset overrides every event, including mid-entry and mid-lockout.
- Event priority per cycle: tmr_reset > key_clear > key_enter > key_valid.
- Entry buffer: shift left by DIGIT_W and insert key_digit at the LSBs. The digit count saturates at CODE_LEN. A digit arriving at full count is dropped and pulses ignore.
- IDLE: enb_lock=1, counters off.
  - key_valid with tmr_enb_inp=1: store digit, cnt=1, go ENTRY.
  - key_valid with tmr_enb_inp=0: pulse ignore, stay.
  - key_enter or key_clear: no effect.
- ENTRY: enb_lock=1, enb_cnt=1 (entry timeout runs).
  - key_valid: stored per the buffer rule.
  - key_clear: buffer and cnt cleared, go IDLE.
  - key_enter: go CHECK.
  - tmr_reset: treated as a failed attempt, go CHECK with forced mismatch.
- CHECK (exactly 1 cycle), then buffer and cnt are cleared:
  - Match requires cnt==CODE_LEN and buffer==code (no forced mismatch). On match: error_counter=0, go UNLOCKED.
  - On mismatch: error_counter+1, saturating at 7. If the new value >= MAX_ERR, go LOCKOUT; otherwise go IDLE.
- UNLOCKED: enb_lock=0, unlocked=1, enb_cnt=1 (auto-relock timer runs).
  - tmr_reset or key_enter: go IDLE (relock).
  - set_req=1 with tmr_enb_set=1: go SET_CODE.
  - key_valid: pulse ignore.
- SET_CODE: enb_lock=0, unlocked=1, disable_cnt=1, enb_cnt=0.
  - Digits are collected per the buffer rule.
  - key_enter with cnt==CODE_LEN: code<=buffer, go UNLOCKED.
  - key_enter with cnt<CODE_LEN: pulse ignore, stay.
  - key_clear: go UNLOCKED, code unchanged.
  - tmr_reset is ignored.
- LOCKOUT: enb_lock=1, gen_stop=1, enb_cnt=1.
  - Every key_valid, key_enter or key_clear pulses ignore.
  - tmr_reset: go IDLE and clear error_counter (see the optional feature).
- enb_cnt and disable_cnt are never both 1.
- ignore is high for at most 1 cycle per dropped key.

Optional Feature:
- Macro: LOCK_PERSIST_ERR_EN.
- Defined: on LOCKOUT exit, error_counter is set to MAX_ERR-1, so a single further failure re-enters LOCKOUT. Only a successful unlock clears it.
- Undefined: error_counter is cleared to 0 on LOCKOUT exit.

Test Plan:
- Correct code: reset, tmr_enb_inp=1, digits 1,2,3,4, then enter -> CHECK 1 cycle, then unlocked=1, enb_lock=0, error_counter=0.
- Wrong code to lockout: digits 1,2,3,5 + enter, three times -> error_counter 1, 2, 3. After the third attempt: gen_stop=1, enb_lock=1. Keys during LOCKOUT pulse ignore. tmr_reset -> IDLE with error_counter=0, or 2 with LOCK_PERSIST_ERR_EN defined.
- Short entry and overflow: digits 1,2,3 + enter -> mismatch, error_counter=1. Then digits 1,2,3,4,9 -> 5th digit pulses ignore; enter -> unlocked=1.
- Code change: from UNLOCKED, set_req=1 with tmr_enb_set=1 -> SET_CODE with disable_cnt=1. Digits 9,8,7,6 + enter -> UNLOCKED. tmr_reset -> IDLE. Then 9876 unlocks and 1234 fails.
- Priority and timeout: in ENTRY, assert tmr_reset and key_enter in the same cycle -> forced mismatch, error_counter+1. In ENTRY, key_clear together with key_enter -> IDLE with no error count.
- Reset mid-operation: reset_n low for 1 cycle during LOCKOUT or SET_CODE -> IDLE, code=16'h1234, error_counter=0, enb_lock=1.
